spike_event_decoder: RTL and testbench

- Upstream stage of the synapse array. Accepts address-event spikes from the routing fabric over a valid/ready handshake and buffers them in a small FIFO.
- Applies a per-event programmable delay, then emits a one-cycle pulse on the input_spike line of the addressed synapse.
- Guarantees that every downstream synapse sees clean, isolated single-cycle spike pulses.

---
 rtl/spike_event_decoder.sv | 154 +++++++++++++++
 tb/tb_spike_event_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_decoder.sv
// Address-event spike decoder: buffers events in a small FIFO, applies a per-event
// delay, then pulses one synapse line. Optional fired_count output: SPIKE_DECODER_FIRED_COUNT_EN.
module spike_event_decoder #(
    parameter int NUM_SYNAPSES = 16,
    parameter int ADDR_WIDTH   = 5,
    parameter int DELAY_WIDTH  = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    ev_valid_i,
    output logic                    ev_ready_o,
    input  logic [ADDR_WIDTH-1:0]   ev_addr_i,
    input  logic [DELAY_WIDTH-1:0]  ev_delay_i,
    output logic [NUM_SYNAPSES-1:0] input_spike_o,
    output logic                    busy_o,
    output logic [7:0]              drop_count_o
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
    ,
    output logic [15:0]             fired_count_o
`endif
);

    // state  | meaning
    // S_IDLE | no event in delay; loads head delay when FIFO non-empty
    // S_WAIT | counting head delay down; pops and fires at zero
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam int                     PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]         DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]    NSYN_C   = (ADDR_WIDTH+1)'(NUM_SYNAPSES);
    localparam logic [NUM_SYNAPSES-1:0] SPIKE_LSB = (NUM_SYNAPSES)'(1);

    logic [ADDR_WIDTH-1:0]   mem_addr  [FIFO_DEPTH];
    logic [DELAY_WIDTH-1:0]  mem_delay [FIFO_DEPTH];

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [0:0]              state_q, state_d;
    logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_SYNAPSES-1:0] spike_q, spike_d;
    logic [7:0]              drop_q, drop_d;
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
    logic [15:0]             fired_q, fired_d;
`endif

    logic accept;
    logic legal;
    logic push;
    logic pop;

    // Ready comes from registered occupancy only, so it never depends on ev_valid_i.
    assign ev_ready_o = rst_ni & (count_q < DEPTH_C);
    assign accept     = ev_valid_i & ev_ready_o;
    assign legal      = ({1'b0, ev_addr_i} < NSYN_C);
    assign push       = accept & legal;
    assign pop        = (state_q == S_WAIT) && (cnt_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        spike_d  = '0;
        drop_d   = drop_q;
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
        fired_d  = fired_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    cnt_d   = mem_delay[rd_ptr_q];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Head is only released here, so it holds its slot for the whole wait.
                    state_d  = S_IDLE;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    spike_d  = SPIKE_LSB << mem_addr[rd_ptr_q];
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (accept && !legal && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 1'b1;
        end
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
        if (pop && (fired_q != 16'hFFFF)) begin
            fired_d = fired_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            spike_q  <= '0;
            drop_q   <= '0;
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
            fired_q  <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            spike_q  <= spike_d;
            drop_q   <= drop_d;
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
            fired_q  <= fired_d;
`endif
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_addr[wr_ptr_q]  <= ev_addr_i;
            mem_delay[wr_ptr_q] <= ev_delay_i;
        end
    end

    assign input_spike_o = spike_q;
    assign busy_o        = (state_q != S_IDLE) | (count_q != '0);
    assign drop_count_o  = drop_q;
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
    assign fired_count_o = fired_q;
`endif

endmodule

// File: tb/tb_spike_event_decoder.sv
// Bench for spike_event_decoder: directed scenarios plus random traffic against an
// event-schedule model (fire time per event from acceptance time and previous fire).
module tb_spike_event_decoder;

    localparam int NS = 16;
    localparam int FD = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ev_valid_i = 1'b0;
    logic        ev_ready_o;
    logic [4:0]  ev_addr_i = '0;
    logic [3:0]  ev_delay_i = '0;
    logic [15:0] input_spike_o;
    logic        busy_o;
    logic [7:0]  drop_count_o;
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
    logic [15:0] fired_count_o;
`endif

    spike_event_decoder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .ev_valid_i    (ev_valid_i),
        .ev_ready_o    (ev_ready_o),
        .ev_addr_i     (ev_addr_i),
        .ev_delay_i    (ev_delay_i),
        .input_spike_o (input_spike_o),
        .busy_o        (busy_o),
        .drop_count_o  (drop_count_o)
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
        ,
        .fired_count_o (fired_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: each legal event fires at max(accept+3, prev_fire+2) + delay; it occupies
    // a FIFO slot from the cycle after acceptance up to (not including) its fire cycle.
    typedef struct {int addr; int fire;} mev_t;
    mev_t mq[$];
    int last_fire = -100;
    int m_drop = 0;
    int m_fired = 0;

    always @(negedge clk_i) begin : model
        logic [15:0] exp_sp;
        int n;
        mev_t e;
        if (!rst_ni) begin
            mq.delete();
            last_fire = -100;
            m_drop = 0;
            m_fired = 0;
            chk("rst_spike", 32'(input_spike_o), 32'h0);
            chk("rst_ready", 32'(ev_ready_o), 32'h0);
            chk("rst_busy", 32'(busy_o), 32'h0);
            chk("rst_drop", 32'(drop_count_o), 32'h0);
        end else begin
            exp_sp = '0;
            while (mq.size() > 0 && mq[0].fire <= cyc) begin
                if (mq[0].fire == cyc) begin
                    exp_sp = 16'(1) << mq[0].addr;
                    if (m_fired < 65535) m_fired++;
                end
                void'(mq.pop_front());
            end
            n = mq.size();
            chk("spike", 32'(input_spike_o), 32'(exp_sp));
            chk("ready", 32'(ev_ready_o), 32'(n < FD));
            chk("busy", 32'(busy_o), 32'(n != 0));
            chk("drop", 32'(drop_count_o), 32'(m_drop));
`ifdef SPIKE_DECODER_FIRED_COUNT_EN
            chk("fired", 32'(fired_count_o), 32'(m_fired));
`endif
            if (ev_valid_i && n < FD) begin
                if (int'(ev_addr_i) < NS) begin
                    e.addr = int'(ev_addr_i);
                    e.fire = ((cyc + 3 > last_fire + 2) ? cyc + 3 : last_fire + 2) + int'(ev_delay_i);
                    last_fire = e.fire;
                    mq.push_back(e);
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end
    end

    typedef struct {int c; logic [15:0] v;} sp_t;
    sp_t sp_log[$];

    always @(negedge clk_i) begin
        sp_t s;
        if (rst_ni && input_spike_o != '0) begin
            s.c = cyc;
            s.v = input_spike_o;
            sp_log.push_back(s);
        end
    end

    task automatic send(input int addr, input int dly, output int acc);
        bit ok;
        ok = 1'b0;
        acc = -1;
        ev_valid_i = 1'b1;
        ev_addr_i  = 5'(addr);
        ev_delay_i = 4'(dly);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (ev_ready_o) begin
                ok = 1'b1;
                acc = cyc;
            end
            @(posedge clk_i);
            #1;
        end
        ev_valid_i = 1'b0;
        if (!ok) chk("send_timeout", 32'h0, 32'h1);
    endtask

    task automatic wait_neg(input int c);
        do @(negedge clk_i); while (cyc < c);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk_i);
            if (!busy_o) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 32'h0, 32'h1);
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a0, a5, x, b;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        // single event, addr 3, delay 0
        sp_log.delete();
        send(3, 0, a);
        wait_neg(a + 1); chk("t1_busy1", 32'(busy_o), 32'h1);
        wait_neg(a + 2); chk("t1_busy2", 32'(busy_o), 32'h1);
        wait_neg(a + 3); chk("t1_busy3", 32'(busy_o), 32'h0);
        chk("t1_spike", 32'(input_spike_o), 32'h0008);
        wait_idle();
        chk("t1_npulse", 32'(sp_log.size()), 32'd1);

        // addr 15, delay 5
        sp_log.delete();
        send(15, 5, a);
        wait_idle();
        chk("t2_npulse", 32'(sp_log.size()), 32'd1);
        if (sp_log.size() == 1) begin
            chk("t2_cyc", 32'(sp_log[0].c - a), 32'd8);
            chk("t2_val", 32'(sp_log[0].v), 32'h8000);
        end

        // five back-to-back events on addr 1, first delay 15
        sp_log.delete();
        send(1, 15, a0);
        for (int i = 0; i < 4; i++) send(1, 0, a5);
        wait_idle();
        chk("t3_accept5", 32'(a5 - a0), 32'd18);
        chk("t3_npulse", 32'(sp_log.size()), 32'd5);
        if (sp_log.size() == 5) begin
            chk("t3_first", 32'(sp_log[0].c - a0), 32'd18);
            chk("t3_val", 32'(sp_log[0].v), 32'h0002);
            chk("t3_second", 32'(sp_log[1].c - a0), 32'd20);
            chk("t3_fifth", 32'(sp_log[4].c - a0), 32'd26);
        end

        // illegal then legal; drop counter saturation
        sp_log.delete();
        send(20, 0, x);
        send(2, 0, x);
        wait_idle();
        chk("t4_drop1", 32'(drop_count_o), 32'd1);
        chk("t4_npulse", 32'(sp_log.size()), 32'd1);
        if (sp_log.size() == 1) chk("t4_val", 32'(sp_log[0].v), 32'h0004);
        for (int i = 0; i < 300; i++) send(16 + int'($urandom_range(0, 15)), 0, x);
        wait_idle();
        chk("t4_drop_sat", 32'(drop_count_o), 32'd255);

        // reset in the middle of a pending delay
        sp_log.delete();
        send(4, 10, a);
        wait_neg(a + 5);
        reset_pulse();
        @(negedge clk_i);
        chk("t5_busy", 32'(busy_o), 32'h0);
        chk("t5_ready", 32'(ev_ready_o), 32'h1);
        repeat (20) @(negedge clk_i);
        chk("t5_nopulse", 32'(sp_log.size()), 32'd0);
        @(posedge clk_i);
        #1;
        send(4, 3, b);
        wait_idle();
        chk("t5_npulse", 32'(sp_log.size()), 32'd1);
        if (sp_log.size() == 1) begin
            chk("t5_cyc", 32'(sp_log[0].c - b), 32'd6);
            chk("t5_val", 32'(sp_log[0].v), 32'h0010);
        end

`ifdef SPIKE_DECODER_FIRED_COUNT_EN
        reset_pulse();
        send(0, 1, x);
        send(7, 2, x);
        send(25, 0, x);
        send(9, 0, x);
        wait_idle();
        chk("t6_fired", 32'(fired_count_o), 32'd3);
`endif

        // random traffic
        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk_i);
                #1;
            end
            send(int'($urandom_range(0, 19)),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)),
                 x);
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
